// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word over a
//   load_valid/load_ready handshake and sends it MSB first on sout, one bit per
//   enabled rising edge. The companion negative-edge shift-left receiver
//   reassembles the word in its original bit order.
//
//   Optional feature: define PISO_PARITY_EN to append an even-parity bit after
//   the data bits. The PAR state and the parity flop exist only in that build.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   enable      in   shift enable; while low, SHIFT/PAR hold
//   load_valid  in   din holds a word to transmit
//   load_ready  out  block is in IDLE and can take a word
//   din         in   parallel word, captured on the handshake edge
//   sout        out  serial data, 0 whenever sout_valid is 0
//   sout_valid  out  a frame bit is on sout
//   done        out  one-cycle pulse after the last bit of a frame
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              sout_valid_q, sout_valid_d;
  logic              done_q, done_d;
  logic              load_ready_q, load_ready_d;
`ifdef PISO_PARITY_EN
  logic              par_q, par_d;
`endif

  // sout is the shift register MSB; the register is all-zero whenever no
  // frame bit is being driven, so no extra gating is needed.
  assign sout       = shreg_q[WIDTH-1];
  assign sout_valid = sout_valid_q;
  assign done       = done_q;
  assign load_ready = load_ready_q;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    sout_valid_d = sout_valid_q;
    done_d       = 1'b0;
`ifdef PISO_PARITY_EN
    par_d        = par_q;
`endif

    case (state_q)
      IDLE: begin
        sout_valid_d = 1'b0;
        // Load is taken regardless of enable; first bit is valid right away.
        if (load_valid) begin
          state_d      = SHIFT;
          shreg_d      = din;
          bitcnt_d     = '0;
          sout_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
          par_d        = ^din;
`endif
        end
      end

      SHIFT: begin
        if (enable) begin
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == LAST_BIT) begin
`ifdef PISO_PARITY_EN
            // Parity rides in the MSB so it appears on sout like a data bit.
            state_d = PAR;
            shreg_d = {par_q, (WIDTH-1)'(0)};
`else
            state_d      = IDLE;
            sout_valid_d = 1'b0;
            done_d       = 1'b1;
`endif
          end
        end
      end

`ifdef PISO_PARITY_EN
      PAR: begin
        if (enable) begin
          state_d      = IDLE;
          shreg_d      = '0;
          sout_valid_d = 1'b0;
          done_d       = 1'b1;
        end
      end
`endif

      default: begin
        state_d      = IDLE;
        shreg_d      = '0;
        sout_valid_d = 1'b0;
      end
    endcase

    load_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef PISO_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
`ifdef PISO_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
//   Self-checking bench for piso_serializer (WIDTH=8). A frame-level model
//   (word + bit position) predicts every output each cycle, and a falling-edge
//   receiver model reassembles frames and compares them with accepted words.
//   Directed frames pin the model with literal expectations; a random phase
//   follows.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_ready, sout, sout_valid, done;

  int errors = 0;
  int checks = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .din        (din),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model (updated on rising edges) ------------
  bit           m_busy;
  logic [W-1:0] m_word;
  int           m_pos;        // bits already consumed in the current frame
  bit           m_done;
  int           cyc;
  logic [W-1:0] acc [0:1023]; // accepted words, in order
  int           acc_cyc [0:1023];
  int           acc_wr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_pos = 0; m_done = 0; m_word = '0;
    end else begin
      cyc++;
      m_done = 0;
      if (!m_busy) begin
        if (load_valid) begin
          m_busy = 1; m_word = din; m_pos = 0;
          acc[acc_wr % 1024] = din;
          acc_cyc[acc_wr % 1024] = cyc;
          acc_wr++;
        end
      end else if (enable) begin
        m_pos++;
        if (m_pos == NB) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  end

  function automatic logic exp_sout();
    if (!m_busy) return 1'b0;
    if (m_pos < W) return m_word[W-1-m_pos];
    return ^m_word;
  endfunction

  // ---------------- per-cycle compare (falling edge) -----------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_sout", 32'(sout), 32'd0);
      chk("rst_sout_valid", 32'(sout_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end else begin
      chk("load_ready", 32'(load_ready), 32'(!m_busy));
      chk("sout_valid", 32'(sout_valid), 32'(m_busy));
      chk("sout", 32'(sout), 32'(exp_sout()));
      chk("done", 32'(done), 32'(m_done));
    end
  end

  // ---------------- receiver model (falling edge) --------------------------
  logic [W-1:0] rx;
  int           rx_cnt;
  int           rd_idx;
  logic [W-1:0] last_rx;
  logic         par_seen;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx = '0; rx_cnt = 0; rd_idx = acc_wr;  // aborted frame is dropped
    end else begin
      if (sout_valid && enable) begin
        if (rx_cnt < W) begin
          rx = {rx[W-2:0], sout};
          rx_cnt++;
        end else begin
          par_seen = sout;
        end
      end
      if (done) begin
        if (rd_idx < acc_wr) chk("rx_word", 32'(rx), 32'(acc[rd_idx % 1024]));
        else chk("rx_spurious_done", 32'(rd_idx), 32'(acc_wr));
        rd_idx++;
        last_rx = rx;
        rx = '0; rx_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load w, optionally stall enable for stall_n cycles starting stall_at
  // cycles after the load edge; returns the number of edges from load to done.
  task automatic frame(input logic [W-1:0] w, input int stall_at, input int stall_n,
                       output int lat);
    load_valid = 1'b1; din = w; enable = 1'b1;
    tick();
    load_valid = 1'b0; din = W'($urandom);
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == stall_at) enable = 1'b0;
      if (lat == stall_at + stall_n) enable = 1'b1;
      tick();
      lat++;
    end
    enable = 1'b1;
    tick();  // let the receiver see done on the falling edge
  endtask

  int lat;
  int a0;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_sout", 32'(sout), 32'd0);
    chk("reset_valid", 32'(sout_valid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("reset_load_ready", 32'(load_ready), 32'd1);
    tick();

    // A5, no stall
    frame(8'hA5, -1, 0, lat);
    chk("a5_latency", 32'(lat), 32'(NB));
    chk("a5_rx", 32'(last_rx), 32'hA5);

    // 3C, enable low for 3 cycles after the 2nd bit
    frame(8'h3C, 2, 3, lat);
    chk("3c_latency", 32'(lat), 32'(NB + 3));
    chk("3c_rx", 32'(last_rx), 32'h3C);

    // back-to-back: load_valid held high, FF then 01
    a0 = acc_wr;
    load_valid = 1'b1; din = 8'hFF; enable = 1'b1;
    tick();
    din = 8'h01;
    for (int i = 0; i < 40 && acc_wr < a0 + 2; i++) tick();
    load_valid = 1'b0;
    for (int i = 0; i < 40 && rd_idx < a0 + 2; i++) tick();
    chk("b2b_gap", 32'(acc_cyc[(a0+1) % 1024] - acc_cyc[a0 % 1024]), 32'(NB + 1));
    chk("b2b_word0", 32'(acc[a0 % 1024]), 32'hFF);
    chk("b2b_word1", 32'(acc[(a0+1) % 1024]), 32'h01);
    chk("b2b_rx1", 32'(last_rx), 32'h01);

    // reset after 4 bits of F0
    load_valid = 1'b1; din = 8'hF0; enable = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sout", 32'(sout), 32'd0);
    chk("abort_valid", 32'(sout_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    frame(8'h81, -1, 0, lat);
    chk("81_latency", 32'(lat), 32'(NB));
    chk("81_rx", 32'(last_rx), 32'h81);

`ifdef PISO_PARITY_EN
    frame(8'h07, -1, 0, lat);
    chk("07_parity", 32'(par_seen), 32'd1);
    chk("07_latency", 32'(lat), 32'd9);
    frame(8'h03, -1, 0, lat);
    chk("03_parity", 32'(par_seen), 32'd0);
`endif

    // random phase
    for (int i = 0; i < 400; i++) begin
      load_valid = ($urandom_range(0, 2) != 0);
      din        = W'($urandom);
      enable     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    // drain
    load_valid = 1'b0; enable = 1'b1;
    repeat (NB + 4) tick();
    chk("drain_all_received", 32'(rd_idx), 32'(acc_wr));
    chk("drain_idle", 32'(load_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
